// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-port, 1-cycle-latency BRAM with locked bursts.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin conflict resolution (default: requester 0 wins).
module bram_port_arbiter #(
   parameter int BW        = 64,
   parameter int AW        = 3,
   parameter int MAX_BURST = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ0_VALID,
   output logic          REQ0_READY,
   input  logic          REQ0_WEN,
   input  logic          REQ0_LOCK,
   input  logic [AW-1:0] REQ0_A,
   input  logic [BW-1:0] REQ0_DI,
   input  logic          REQ1_VALID,
   output logic          REQ1_READY,
   input  logic          REQ1_WEN,
   input  logic          REQ1_LOCK,
   input  logic [AW-1:0] REQ1_A,
   input  logic [BW-1:0] REQ1_DI,
   output logic          RSP0_VALID,
   output logic          RSP1_VALID,
   output logic [BW-1:0] RSP_DO,
   output logic          BRAM_CSN,
   output logic          BRAM_WEN,
   output logic [AW-1:0] BRAM_A,
   output logic [BW-1:0] BRAM_DI,
   input  logic [BW-1:0] BRAM_DOUT
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic LOCK_ALLOWED = (MAX_BURST > 1);
   localparam logic [CW-1:0] LAST_BEAT_CNT = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {IDLE, OWN_0, OWN_1} state_t;

   state_t          state_reg;
   logic [CW-1:0]   burst_cnt_reg;
   logic            last_grant_reg;
   logic [1:0]      rsp_valid_reg;

   logic [1:0]      req_valid;
   logic [1:0]      req_wen;
   logic [1:0]      req_lock;
   logic [AW-1:0]   req_a  [2];
   logic [BW-1:0]   req_di [2];

   logic [1:0]      grant_vec;
   logic            grant_idx;
   logic            granted;
   logic            conflict_pick1;

   assign req_valid = {REQ1_VALID, REQ0_VALID};
   assign req_wen   = {REQ1_WEN, REQ0_WEN};
   assign req_lock  = {REQ1_LOCK, REQ0_LOCK};
   assign req_a[0]  = REQ0_A;
   assign req_a[1]  = REQ1_A;
   assign req_di[0] = REQ0_DI;
   assign req_di[1] = REQ1_DI;

`ifdef ARB_ROUND_ROBIN_EN
   assign conflict_pick1 = ~last_grant_reg;
`else
   // last_grant is tracked in both builds; fixed priority never lets it win a conflict
   assign conflict_pick1 = last_grant_reg & 1'b0;
`endif

   // Grant is gated by reset so the port and READYs drop the instant reset asserts
   always_comb begin
      grant_vec = 2'b00;
      if (!RST) begin
         case (state_reg)
            IDLE: begin
               if (req_valid == 2'b11)
                  grant_vec = conflict_pick1 ? 2'b10 : 2'b01;
               else
                  grant_vec = req_valid;
            end
            OWN_0:   grant_vec = {1'b0, req_valid[0]};
            OWN_1:   grant_vec = {req_valid[1], 1'b0};
            default: grant_vec = 2'b00;
         endcase
      end
   end

   assign granted   = |grant_vec;
   assign grant_idx = grant_vec[1];

   assign REQ0_READY = grant_vec[0];
   assign REQ1_READY = grant_vec[1];

   assign BRAM_CSN = ~granted;
   assign BRAM_WEN = granted ? req_wen[grant_idx] : 1'b1;
   assign BRAM_A   = granted ? req_a[grant_idx]   : '0;
   assign BRAM_DI  = granted ? req_di[grant_idx]  : '0;

   assign RSP0_VALID = rsp_valid_reg[0];
   assign RSP1_VALID = rsp_valid_reg[1];
   assign RSP_DO     = BRAM_DOUT;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg      <= IDLE;
         burst_cnt_reg  <= '0;
         last_grant_reg <= 1'b1;
         rsp_valid_reg  <= 2'b00;
      end else begin
         // A read beat this cycle means its data leaves the BRAM next cycle
         rsp_valid_reg <= grant_vec & req_wen;
         if (granted)
            last_grant_reg <= grant_idx;
         case (state_reg)
            IDLE: begin
               if (granted && req_lock[grant_idx] && LOCK_ALLOWED) begin
                  state_reg     <= grant_idx ? OWN_1 : OWN_0;
                  burst_cnt_reg <= CW'(1);
               end
            end
            OWN_0, OWN_1: begin
               if (!granted || !req_lock[grant_idx] || burst_cnt_reg == LAST_BEAT_CNT) begin
                  state_reg     <= IDLE;
                  burst_cnt_reg <= '0;
               end else begin
                  burst_cnt_reg <= burst_cnt_reg + CW'(1);
               end
            end
            default: begin
               state_reg     <= IDLE;
               burst_cnt_reg <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model of ownership, memory contents and expected responses.
module tb_bram_port_arbiter;

   localparam int BW = 64;
   localparam int AW = 3;
   localparam int MB = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          REQ0_VALID = 0, REQ0_WEN = 1, REQ0_LOCK = 0;
   logic          REQ1_VALID = 0, REQ1_WEN = 1, REQ1_LOCK = 0;
   logic [AW-1:0] REQ0_A = '0, REQ1_A = '0;
   logic [BW-1:0] REQ0_DI = '0, REQ1_DI = '0;
   logic          REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID;
   logic [BW-1:0] RSP_DO;
   logic          BRAM_CSN, BRAM_WEN;
   logic [AW-1:0] BRAM_A;
   logic [BW-1:0] BRAM_DI;
   logic [BW-1:0] BRAM_DOUT;

   always #5 CLK = ~CLK;

   bram_port_arbiter #(.BW(BW), .AW(AW), .MAX_BURST(MB)) dut (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_WEN(REQ0_WEN),
      .REQ0_LOCK(REQ0_LOCK), .REQ0_A(REQ0_A), .REQ0_DI(REQ0_DI),
      .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_WEN(REQ1_WEN),
      .REQ1_LOCK(REQ1_LOCK), .REQ1_A(REQ1_A), .REQ1_DI(REQ1_DI),
      .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID), .RSP_DO(RSP_DO),
      .BRAM_CSN(BRAM_CSN), .BRAM_WEN(BRAM_WEN), .BRAM_A(BRAM_A),
      .BRAM_DI(BRAM_DI), .BRAM_DOUT(BRAM_DOUT)
   );

   // Simple single-port synchronous-read BRAM attached to the arbiter
   logic [BW-1:0] bram_mem [8];
   logic [BW-1:0] dout_q = '0;
   always @(posedge CLK) begin
      if (!BRAM_CSN) begin
         if (!BRAM_WEN) bram_mem[BRAM_A] <= BRAM_DI;
         else           dout_q <= bram_mem[BRAM_A];
      end
   end
   assign BRAM_DOUT = dout_q;

   // Reference model state
   int            m_own;      // -1 = nobody owns the port
   int            m_beats;
   bit            m_last;
   bit [1:0]      m_rv;
   logic [BW-1:0] m_rd;
   logic [BW-1:0] m_mem [8];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant();
      bit [1:0] v;
      v = {REQ1_VALID, REQ0_VALID};
      if (RST) return -1;
      if (m_own >= 0) return v[m_own] ? m_own : -1;
      if (v == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
         return m_last ? 0 : 1;
`else
         return 0;
`endif
      end
      if (v[0]) return 0;
      if (v[1]) return 1;
      return -1;
   endfunction

   task automatic model_reset();
      m_own = -1; m_beats = 0; m_last = 1'b1; m_rv = 2'b00;
   endtask

   // One clock cycle: inputs already applied; check at the falling edge, then advance the model
   task automatic cycle(input string tag, output int g);
      logic          wen_g, lock_g;
      logic [AW-1:0] a_g;
      logic [BW-1:0] d_g;
      g      = model_grant();
      wen_g  = (g == 1) ? REQ1_WEN  : REQ0_WEN;
      lock_g = (g == 1) ? REQ1_LOCK : REQ0_LOCK;
      a_g    = (g == 1) ? REQ1_A    : REQ0_A;
      d_g    = (g == 1) ? REQ1_DI   : REQ0_DI;
      @(negedge CLK);
      check({tag, ".ready0"}, REQ0_READY, 64'(g == 0));
      check({tag, ".ready1"}, REQ1_READY, 64'(g == 1));
      check({tag, ".csn"}, BRAM_CSN, 64'(g < 0));
      check({tag, ".wen"}, BRAM_WEN, (g < 0) ? 64'd1 : 64'(wen_g));
      check({tag, ".addr"}, BRAM_A, (g < 0) ? 64'd0 : 64'(a_g));
      check({tag, ".di"}, BRAM_DI, (g < 0) ? 64'd0 : d_g);
      check({tag, ".rsp0v"}, RSP0_VALID, 64'(m_rv[0]));
      check({tag, ".rsp1v"}, RSP1_VALID, 64'(m_rv[1]));
      if (m_rv != 2'b00) check({tag, ".rspdo"}, RSP_DO, m_rd);
      $display("[TB] %s grant=%0d wen=%0b a=%0d di=%h rsp=%b do=%h",
               tag, g, wen_g, a_g, d_g, {RSP1_VALID, RSP0_VALID}, RSP_DO);
      m_rv = 2'b00;
      if (g >= 0) begin
         if (wen_g) begin
            m_rv[g] = 1'b1;
            m_rd    = m_mem[a_g];
         end else begin
            m_mem[a_g] = d_g;
         end
         m_last = g[0];
      end
      if (m_own >= 0) begin
         if (g < 0) m_own = -1;
         else begin
            m_beats++;
            if (!lock_g || m_beats >= MB) m_own = -1;
         end
      end else if (g >= 0 && lock_g && MB > 1) begin
         m_own   = g;
         m_beats = 1;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      REQ0_VALID = 0; REQ1_VALID = 0; REQ0_LOCK = 0; REQ1_LOCK = 0;
      RST = 1'b1;
      model_reset();
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   initial begin
      int g;
      int a1;
      for (int i = 0; i < 8; i++) begin
         bram_mem[i] = '0;
         m_mem[i]    = '0;
      end
      model_reset();

      // Reset values hold even while both requesters are valid
      REQ0_VALID = 1; REQ1_VALID = 1;
      #2;
      check("reset.ready0", REQ0_READY, 0);
      check("reset.ready1", REQ1_READY, 0);
      check("reset.csn", BRAM_CSN, 1);
      check("reset.wen", BRAM_WEN, 1);
      check("reset.addr", BRAM_A, 0);
      check("reset.di", BRAM_DI, 0);
      check("reset.rsp0v", RSP0_VALID, 0);
      check("reset.rsp1v", RSP1_VALID, 0);
      @(posedge CLK); #1;
      do_reset();

      // Single write then read-back on requester 0
      REQ0_VALID = 1; REQ0_WEN = 0; REQ0_A = 3; REQ0_DI = 64'hDEAD_BEEF_0000_0001;
      cycle("wr", g);
      REQ0_WEN = 1;
      cycle("rd", g);
      REQ0_VALID = 0;
      cycle("rd.rsp", g);
      check("rd.data", RSP_DO, 64'hDEAD_BEEF_0000_0001);

      // Unlocked conflict for four cycles
      do_reset();
      REQ0_VALID = 1; REQ1_VALID = 1; REQ0_WEN = 1; REQ1_WEN = 1;
      for (int i = 0; i < 4; i++) begin
         REQ0_A = AW'(i); REQ1_A = AW'(7 - i);
         cycle("conflict", g);
      end
      REQ0_VALID = 0; REQ1_VALID = 0;
      cycle("conflict.drain", g);

      // Locked burst on requester 1 against a continuously valid requester 0
      do_reset();
      a1 = 0;
      REQ1_VALID = 1; REQ1_WEN = 1; REQ1_LOCK = 1;
      REQ0_WEN = 1; REQ0_A = 2;
      for (int i = 0; i < 12 && a1 < 6; i++) begin
         REQ1_A = AW'(a1);
         REQ0_VALID = (i > 0);
         cycle("burst", g);
         if (g == 1) a1++;
      end
      REQ0_VALID = 0; REQ1_VALID = 0; REQ1_LOCK = 0;
      cycle("burst.drain", g);

      // Lock abandoned by requester 0 dropping VALID for a cycle
      do_reset();
      REQ0_VALID = 1; REQ0_LOCK = 1; REQ0_WEN = 0; REQ0_A = 5; REQ0_DI = 64'h0123_4567_89AB_CDEF;
      REQ1_VALID = 1; REQ1_WEN = 1; REQ1_A = 5;
      cycle("abandon.lock", g);
      REQ0_VALID = 0;
      cycle("abandon.gap", g);
      cycle("abandon.next", g);
      REQ1_VALID = 0;
      cycle("abandon.drain", g);

      // Reset asserted mid-burst with a read response outstanding
      do_reset();
      REQ1_VALID = 1; REQ1_LOCK = 1; REQ1_WEN = 1; REQ1_A = 3;
      cycle("rstburst.b0", g);
      REQ1_A = 5;
      cycle("rstburst.b1", g);
      check("rstburst.pending", RSP1_VALID, 1);
      RST = 1'b1;
      #1;
      check("rstburst.rsp1v", RSP1_VALID, 0);
      check("rstburst.csn", BRAM_CSN, 1);
      check("rstburst.ready1", REQ1_READY, 0);
      model_reset();
      @(posedge CLK); #1;
      RST = 1'b0;
      REQ0_VALID = 1; REQ0_WEN = 1; REQ0_LOCK = 0; REQ0_A = 3; REQ1_LOCK = 0;
      cycle("rstburst.first", g);
      check("rstburst.winner", 64'(g), 0);
      REQ0_VALID = 0; REQ1_VALID = 0;
      cycle("rstburst.drain", g);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         REQ0_VALID = ($urandom_range(3) != 0);
         REQ1_VALID = ($urandom_range(3) != 0);
         REQ0_WEN   = $urandom_range(1);
         REQ1_WEN   = $urandom_range(1);
         REQ0_LOCK  = $urandom_range(1);
         REQ1_LOCK  = $urandom_range(1);
         REQ0_A     = AW'($urandom_range(7));
         REQ1_A     = AW'($urandom_range(7));
         REQ0_DI    = {$urandom, $urandom};
         REQ1_DI    = {$urandom, $urandom};
         cycle("rand", g);
      end
      REQ0_VALID = 0; REQ1_VALID = 0;
      cycle("rand.drain", g);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter and sequencer for one single-port, synchronous-read BRAM. The BRAM has an active-low chip select, WEN=1 for read and WEN=0 for write, and 1-cycle read latency. Typical pairing: requester 0 is the AXI/DMA loader and requester 1 is the PE-array fetch unit. The block does per-cycle arbitration with valid/ready handshakes, supports locked bursts with a fairness cap, and returns read data tagged to the issuing requester.

## Interface
Parameters:
- BW, 64, data bit width (matches BRAM BW)
- AW, 3, address width (matches BRAM AW)
- MAX_BURST, 8, max consecutive beats a locked owner may hold the port (≥1)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ0_VALID / REQ1_VALID  in  1  request present
- REQ0_READY / REQ1_READY  out  1  request accepted this cycle (combinational)
- REQ0_WEN / REQ1_WEN  in  1  1 = read, 0 = write (BRAM convention)
- REQ0_LOCK / REQ1_LOCK  in  1  keep ownership after this beat
- REQ0_A / REQ1_A  in  AW  address
- REQ0_DI / REQ1_DI  in  BW  write data
- RSP0_VALID / RSP1_VALID  out  1  read data valid for that requester
- RSP_DO  out  BW  read data, shared; qualified by RSPx_VALID
- BRAM_CSN  out  1  BRAM chip select, active low
- BRAM_WEN  out  1  to BRAM WEN
- BRAM_A  out  AW  to BRAM A
- BRAM_DI  out  BW  to BRAM DI
- BRAM_DOUT  in  BW  from BRAM DOUT

## Operation
- Transfer on requester i means REQi_VALID & REQi_READY in the same cycle. At most one transfer per cycle.
- BRAM_CSN, BRAM_WEN, BRAM_A and BRAM_DI are driven combinationally from the granted requester's inputs.
  - With a grant: BRAM_CSN=0.
  - With no grant: BRAM_CSN=1, BRAM_WEN=1, BRAM_A=0, BRAM_DI=0.
- FSM states:
  - IDLE
    - Grant goes to the single valid requester.
    - If both are valid, grant follows the priority rule (see Configuration).
    - On a transfer with LOCK=1, go to OWN_i and set burst_cnt=1. Otherwise stay in IDLE.
  - OWN_i
    - Only requester i can be granted. READY of the other requester is held at 0.
    - On a transfer with LOCK=0, go to IDLE.
    - On a transfer with burst_cnt==MAX_BURST-1, go to IDLE (forced release, whatever the LOCK value). Otherwise increment burst_cnt.
    - If REQi_VALID=0 for a cycle, the lock is abandoned: go to IDLE the next cycle, with no grant that cycle.
- The last_grant register updates on every transfer.
- burst_cnt width is $clog2(MAX_BURST+1). If MAX_BURST=1, LOCK is effectively ignored.
- Responses:
  - RSPi_VALID is registered and is set when the previous cycle held a read transfer from i.
  - RSP_DO = BRAM_DOUT passthrough.
  - Writes produce no response.
  - There is no response backpressure: requesters must sink responses.

## Timing
- Reset values:
  - REQx_READY=0 and RSPx_VALID=0.
  - BRAM_CSN=1, BRAM_WEN=1, BRAM_A=0, BRAM_DI=0.
  - State=IDLE, burst_cnt=0, last_grant=1, so requester 0 wins the first conflict.
- Read latency: a transfer in cycle N gives RSPi_VALID=1 and valid RSP_DO in cycle N+1. Back-to-back reads give one response per cycle.
- Write: the BRAM is updated at the edge closing the transfer cycle. A read to the same address in the next cycle returns the new data.
- Grant is combinational from VALID and registered state. VALID must not depend combinationally on READY.
- Both requesters valid in IDLE: exactly one READY high; the loser stalls with no data loss.
- Reset mid-burst or with a response pending:
  - Asynchronous return to IDLE.
  - The pending RSP_VALID is dropped.
  - BRAM_CSN deasserts immediately.

## Configuration
- ARB_ROUND_ROBIN_EN
  - Defined: on a conflict in IDLE, grant the requester that is not last_grant, so two continuously valid requesters with LOCK=0 alternate 0,1,0,1.
  - Undefined: fixed priority, requester 0 always wins conflicts in IDLE. last_grant is still maintained but unused.
  - MAX_BURST release applies in both modes.

## Test plan
- Single write then read:
  - Stimulus: REQ0 writes 64'hDEAD_BEEF_0000_0001 to A=3, then reads A=3 in the next cycle.
  - Required: BRAM_CSN=0 in both cycles; RSP0_VALID=1 one cycle after the read with RSP_DO=64'hDEAD_BEEF_0000_0001; RSP1_VALID stays 0.
- Conflict, LOCK=0, both valid for 4 cycles:
  - With ARB_ROUND_ROBIN_EN: grants 0,1,0,1.
  - Without it: grants 0,0,0,0, REQ1_READY never 1.
- Locked burst with MAX_BURST=4:
  - Stimulus: REQ1 reads A=0..5 with LOCK=1 while REQ0 is valid.
  - Required: REQ1 gets 4 consecutive grants, then returns to IDLE; REQ0 wins the next conflict in round-robin mode.
- Lock abandon:
  - Stimulus: REQ0 locks, then drops VALID for one cycle.
  - Required: no grant that cycle; REQ1 is granted in the following cycle.
- Reset mid-burst:
  - Stimulus: assert RST during OWN_1 with a read response pending.
  - Required: RSP1_VALID=0 and BRAM_CSN=1 immediately; after release, requester 0 wins the first conflict.
